// File: rtl/pb_debounce_pkg.sv
// pb_debounce_pkg: shared debounce FSM state encodings and default timing.
package pb_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RCHK = 2'd1,
        S_HIGH = 2'd2,
        S_FCHK = 2'd3
    } pb_state_e;

    // 20 ms at 50 MHz
    localparam int DB_CYCLES_50MHZ = 1000000;

endpackage

// File: rtl/pb_debounce_ch.sv
// pb_debounce_ch: one button channel (synchronizer, saturating counter, debounce FSM).
module pb_debounce_ch
    import pb_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    pb_state_e              state_q, state_d;
    logic                   level_q, level_d, press_q, press_d, rel_q, rel_d;
    logic                   s;

    assign s          = sync_q[SYNC_STAGES-1];
    assign pb_level   = level_q;
    assign pb_press   = press_q;
    assign pb_release = rel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_LOW;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pb_raw};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            S_LOW: if (s) begin
                state_d = S_RCHK;
                cnt_d   = '0;
            end
            S_RCHK: if (!s) begin
                state_d = S_LOW;
                cnt_d   = '0;
            end else if (cnt_q == LAST) begin
                state_d = S_HIGH;
                cnt_d   = '0;
                level_d = 1'b1;
                press_d = 1'b1;
            end
            S_HIGH: if (!s) begin
                state_d = S_FCHK;
                cnt_d   = '0;
            end
            S_FCHK: if (s) begin
                state_d = S_HIGH;
                cnt_d   = '0;
            end else if (cnt_q == LAST) begin
                state_d = S_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
                rel_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pb_debounce.sv
// pb_debounce: NUM_BTN independent debounced pushbutton channels with press/release pulses.
module pb_debounce
    import pb_debounce_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_50MHZ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pb_raw,
    output logic [NUM_BTN-1:0] pb_level,
    output logic [NUM_BTN-1:0] pb_press,
    output logic [NUM_BTN-1:0] pb_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        pb_debounce_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pb_raw    (pb_raw[i]),
            .pb_level  (pb_level[i]),
            .pb_press  (pb_press[i]),
            .pb_release(pb_release[i])
        );
    end

endmodule
